rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Write-back scheduler and hazard scoreboard in front of the 32x32 register file's single write port.
- Arbitrates NUM_REQ write-back sources (ALU pipe, load unit, mul/div unit) onto the one write port, round-robin.
- Tracks in-flight destination registers so the decode stage can stall on RAW hazards.
- Drives the register file's enable/writeadd/writedata directly from registered outputs.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..4).
- XLEN, 32, data width.
- AW, 5, register address width.
- CNT_W, 2, width of the per-register in-flight counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a write-back pending.
- req_ready  out  NUM_REQ  requester i granted this cycle (combinational).
- req_addr  in  NUM_REQ*AW  destination register, requester i in slice [i*AW +: AW].
- req_data  in  NUM_REQ*XLEN  write data, requester i in slice [i*XLEN +: XLEN].
- rf_enable  out  1  register-file write enable (registered).
- rf_writeadd  out  AW  register-file write address (registered).
- rf_writedata  out  XLEN  register-file write data (registered).
- issue_valid  in  1  decode issues an instruction that writes issue_rd.
- issue_rd  in  AW  destination of the issuing instruction.
- issue_ready  out  1  low when issue_rd's counter is saturated.
- query_rs1  in  AW  source register 1 to check.
- query_rs2  in  AW  source register 2 to check.
- rs1_busy  out  1  rs1 has an uncommitted write.
- rs2_busy  out  1  rs2 has an uncommitted write.

Behaviour:
- Reset values:
  - rf_enable=0, rf_writeadd=0, rf_writedata=0.
  - RR pointer=0.
  - All counters=0, so rs1_busy=rs2_busy=0 and issue_ready=1.
- Arbitration:
  - Round-robin, starting at the pointer.
  - The first valid requester at or after the pointer (modulo NUM_REQ) wins.
  - req_ready is one-hot or zero, and is asserted only with its req_valid.
  - A transfer occurs on valid&&ready.
  - After a grant to requester g, the pointer becomes (g+1) mod NUM_REQ. With no grant, the pointer holds.
- Latency:
  - A transfer in cycle N drives rf_enable=1 with its addr/data in cycle N+1.
  - The register file writes at the end of cycle N+1.
  - With no transfer, rf_enable=0 next cycle; rf_writeadd and rf_writedata hold.
- Output stage always drains, so throughput is one write per cycle.
- x0 handling:
  - A transfer with addr 0 is accepted, but rf_enable stays 0.
  - issue_rd=0 does not touch any counter.
  - Queries of x0 always return busy=0.
- Scoreboard: per-register counter cnt[r], CNT_W bits.
  - Increment on issue_valid&&issue_ready for r=issue_rd.
  - Decrement on a transfer with addr r.
  - Increment and decrement of the same r in the same cycle leave cnt[r] unchanged.
  - issue_ready = (cnt[issue_rd] != max) OR a same-cycle decrement of issue_rd.
  - A decrement at cnt=0 is a protocol error: counter holds at 0; assertion in simulation.
- Busy:
  - rsX_busy = (cnt[rsX] != 0) OR (rf_enable && rf_writeadd == rsX).
  - This covers the cycle between grant and register-file commit.
  - Outputs are combinational from state and query inputs.
- Reset asserted mid-operation:
  - Everything clears immediately.
  - Pending requests are re-arbitrated after deassertion.
  - A write in flight in the output stage is dropped.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - Adds outputs rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data.
  - fwd_valid=1 when rf_enable && rf_writeadd == rsX && rsX != 0 && cnt[rsX] == 0, with data = rf_writedata.
  - When fwd_valid=1, rsX_busy is 0 for that register.
- Not defined: the ports are absent, and busy follows the base rule.

Decomposition:
- Package rf_wb_pkg holds:
  - REG_ADDR_W=5, XLEN=32.
  - Requester index constants: REQ_ALU=0, REQ_LSU=1, REQ_MDU=2.
  - Typedef for the write-back request bundle {addr, data}.
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin grant with pointer update. Reused later for other shared ports.

Test Plan:
- Reset, then idle → rf_enable=0, rs1_busy=rs2_busy=0, issue_ready=1.
- All three requesters valid in the same cycle:
  - Addrs 5/6/7, data 0xA5/0xB6/0xC7, pointer=0.
  - Grants go 0,1,2 on consecutive cycles.
  - rf_writeadd=5,6,7 one cycle later each; rf_enable high for 3 cycles.
- Issue rd=3, then query rs1=3:
  - rs1_busy=1 until the cycle after requester 1 transfers addr 3.
  - In that cycle rs1_busy is still 1 via the output stage; it is 0 in the cycle after.
- Issue rd=9 three times (CNT_W=2) → issue_ready=0 on the fourth attempt.
- Issue rd=9 while a write to 9 transfers in the same cycle → cnt[9] unchanged.
- Transfer with addr 0, data 0xFFFF_FFFF → req_ready=1, rf_enable stays 0.
- Reset pulse while requests are pending → outputs clear asynchronously, then arbitration restarts at requester 0.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file write-back path.
package rf_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter.sv
// N-wide round-robin arbiter: the first requester at or after the pointer wins,
// and the pointer moves just past the winner. Generic so other shared ports can reuse it.
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gidx;
    logic          found;

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[PW'((int'(ptr_q) + k) % N)]) begin
                found = 1'b1;
                gidx  = PW'((int'(ptr_q) + k) % N);
            end
        end
        grant = found ? (N'(1) << gidx) : '0;
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler and RAW hazard scoreboard for the register file's single write port.
// Optional forwarding from the output stage is enabled by defining RF_WB_BYPASS_EN.
module rf_wb_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = rf_wb_pkg::XLEN,
    parameter int AW      = rf_wb_pkg::REG_ADDR_W,
    parameter int CNT_W   = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*AW-1:0]   req_addr,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic                    rf_enable,
    output logic [AW-1:0]           rf_writeadd,
    output logic [XLEN-1:0]         rf_writedata,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    output logic                    issue_ready,
    input  logic [AW-1:0]           query_rs1,
    input  logic [AW-1:0]           query_rs2,
`ifdef RF_WB_BYPASS_EN
    output logic                    rs1_fwd_valid,
    output logic [XLEN-1:0]         rs1_fwd_data,
    output logic                    rs2_fwd_valid,
    output logic [XLEN-1:0]         rs2_fwd_data,
`endif
    output logic                    rs1_busy,
    output logic                    rs2_busy
);

    localparam int NREG = 1 << AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic [AW-1:0]      sel_addr;
    logic [XLEN-1:0]    sel_data;

    logic               rf_enable_q, rf_enable_d;
    logic [AW-1:0]      rf_writeadd_q, rf_writeadd_d;
    logic [XLEN-1:0]    rf_writedata_q, rf_writedata_d;

    logic [CNT_W-1:0]   cnt_q [NREG];
    logic [CNT_W-1:0]   cnt_d [NREG];
    logic               dec_any, inc_any, inc_r, dec_r, dec_err;
    logic               rs1_cnt_nz, rs2_cnt_nz, rs1_hit, rs2_hit;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clock (clock),
        .reset (reset),
        .req   (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i*AW +: AW];
                sel_data = sel_data | req_data[i*XLEN +: XLEN];
            end
        end
    end

    // x0 writes are consumed from the requester but never reach the register file.
    always_comb begin
        rf_enable_d    = xfer && (sel_addr != '0);
        rf_writeadd_d  = xfer ? sel_addr : rf_writeadd_q;
        rf_writedata_d = xfer ? sel_data : rf_writedata_q;
    end

    always_comb begin
        dec_any     = xfer && (sel_addr != '0);
        issue_ready = (cnt_q[issue_rd] != CNT_MAX) || (dec_any && (sel_addr == issue_rd));
        inc_any     = issue_valid && issue_ready && (issue_rd != '0);
        dec_err     = 1'b0;
        inc_r       = 1'b0;
        dec_r       = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            inc_r    = inc_any && (issue_rd == AW'(r));
            dec_r    = dec_any && (sel_addr == AW'(r));
            if (inc_r && !dec_r) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec_r && !inc_r) begin
                if (cnt_q[r] == '0) begin
                    dec_err = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    // The output-stage term covers the cycle between grant and register-file commit.
    always_comb begin
        rs1_cnt_nz = (cnt_q[query_rs1] != '0);
        rs2_cnt_nz = (cnt_q[query_rs2] != '0);
        rs1_hit    = rf_enable_q && (rf_writeadd_q == query_rs1) && (query_rs1 != '0);
        rs2_hit    = rf_enable_q && (rf_writeadd_q == query_rs2) && (query_rs2 != '0);
`ifdef RF_WB_BYPASS_EN
        rs1_fwd_valid = rs1_hit && !rs1_cnt_nz;
        rs2_fwd_valid = rs2_hit && !rs2_cnt_nz;
        rs1_fwd_data  = rf_writedata_q;
        rs2_fwd_data  = rf_writedata_q;
        rs1_busy      = (query_rs1 != '0) && (rs1_cnt_nz || (rs1_hit && !rs1_fwd_valid));
        rs2_busy      = (query_rs2 != '0) && (rs2_cnt_nz || (rs2_hit && !rs2_fwd_valid));
`else
        rs1_busy = (query_rs1 != '0) && (rs1_cnt_nz || rs1_hit);
        rs2_busy = (query_rs2 != '0) && (rs2_cnt_nz || rs2_hit);
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_enable_q    <= 1'b0;
            rf_writeadd_q  <= '0;
            rf_writedata_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            rf_enable_q    <= rf_enable_d;
            rf_writeadd_q  <= rf_writeadd_d;
            rf_writedata_q <= rf_writedata_d;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // A write-back for a register with no outstanding issue is a requester protocol error.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!dec_err);
        end
    end

    assign rf_enable    = rf_enable_q;
    assign rf_writeadd  = rf_writeadd_q;
    assign rf_writedata = rf_writedata_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: arbitration order, output-stage latency,
// scoreboard saturation, x0 handling and asynchronous reset.
module tb_rf_wb_scheduler;

    localparam int NUM_REQ = 3;
    localparam int XLEN    = 32;
    localparam int AW      = 5;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*AW-1:0]   req_addr = '0;
    logic [NUM_REQ*XLEN-1:0] req_data = '0;
    logic                    rf_enable;
    logic [AW-1:0]           rf_writeadd;
    logic [XLEN-1:0]         rf_writedata;
    logic                    issue_valid = 1'b0;
    logic [AW-1:0]           issue_rd = '0;
    logic                    issue_ready;
    logic [AW-1:0]           query_rs1 = '0;
    logic [AW-1:0]           query_rs2 = '0;
    logic                    rs1_busy, rs2_busy;
`ifdef RF_WB_BYPASS_EN
    logic                    rs1_fwd_valid, rs2_fwd_valid;
    logic [XLEN-1:0]         rs1_fwd_data, rs2_fwd_data;
`endif

    int checks = 0;
    int errors = 0;
    logic [AW+XLEN-1:0] exp_q[$];

    always #5 clock = ~clock;

    rf_wb_scheduler #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .AW(AW), .CNT_W(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .rf_enable    (rf_enable),
        .rf_writeadd  (rf_writeadd),
        .rf_writedata (rf_writedata),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .query_rs1    (query_rs1),
        .query_rs2    (query_rs2),
`ifdef RF_WB_BYPASS_EN
        .rs1_fwd_valid(rs1_fwd_valid),
        .rs1_fwd_data (rs1_fwd_data),
        .rs2_fwd_valid(rs2_fwd_valid),
        .rs2_fwd_data (rs2_fwd_data),
`endif
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy)
    );

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        req_addr[i*AW +: AW]     = a;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic check_rf_write(input string tag);
        logic [AW+XLEN-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=write expected=empty_queue", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_en"},   64'(rf_enable),    64'd1);
            check({tag, "_addr"}, 64'(rf_writeadd),  64'(e[AW+XLEN-1:XLEN]));
            check({tag, "_data"}, 64'(rf_writedata), 64'(e[XLEN-1:0]));
        end
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        check("rst_en",    64'(rf_enable),   64'd0);
        check("rst_busy1", 64'(rs1_busy),    64'd0);
        check("rst_busy2", 64'(rs2_busy),    64'd0);
        check("rst_ready", 64'(issue_ready), 64'd1);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check("idle_en",   64'(rf_enable),   64'd0);
        check("idle_addr", 64'(rf_writeadd), 64'd0);

        // Issue rd 5, 6, 7 so their write-backs are legal
        next_cycle();
        issue_valid = 1'b1;
        issue_rd = 5'd5;
        @(negedge clock);
        check("iss5_ready", 64'(issue_ready), 64'd1);
        next_cycle();
        issue_rd = 5'd6;
        next_cycle();
        issue_rd = 5'd7;

        // All three requesters valid together, pointer at 0
        next_cycle();
        issue_valid = 1'b0;
        query_rs1 = 5'd5;
        query_rs2 = 5'd6;
        req_valid = 3'b111;
        set_req(0, 5'd5, 32'hA5);
        set_req(1, 5'd6, 32'hB6);
        set_req(2, 5'd7, 32'hC7);
        @(negedge clock);
        check("A_busy1", 64'(rs1_busy),  64'd1);
        check("A_busy2", 64'(rs2_busy),  64'd1);
        check("A_grant", 64'(req_ready), 64'b001);
        check("A_en",    64'(rf_enable), 64'd0);
        exp_q.push_back({5'd5, 32'hA5});
        exp_q.push_back({5'd6, 32'hB6});
        exp_q.push_back({5'd7, 32'hC7});
        next_cycle();
        req_valid = 3'b110;
        @(negedge clock);
        check("B_grant", 64'(req_ready), 64'b010);
        check_rf_write("B_wr");
        check("B_busy1_stage", 64'(rs1_busy), 64'd1);
        next_cycle();
        req_valid = 3'b100;
        @(negedge clock);
        check("C_grant", 64'(req_ready), 64'b100);
        check_rf_write("C_wr");
        check("C_busy1_clear", 64'(rs1_busy), 64'd0);
        check("C_busy2_stage", 64'(rs2_busy), 64'd1);
        next_cycle();
        req_valid = 3'b000;
        @(negedge clock);
        check("D_grant", 64'(req_ready), 64'b000);
        check_rf_write("D_wr");

        // Output stage idles and holds; issue rd 3
        next_cycle();
        issue_valid = 1'b1;
        issue_rd = 5'd3;
        @(negedge clock);
        check("E_en",   64'(rf_enable),   64'd0);
        check("E_hold", 64'(rf_writeadd), 64'd7);
        check("E_ready", 64'(issue_ready), 64'd1);

        // Requester 1 writes back x3 (pointer 0, only requester 1 valid)
        next_cycle();
        issue_valid = 1'b0;
        query_rs1 = 5'd3;
        req_valid = 3'b010;
        set_req(1, 5'd3, 32'h33);
        @(negedge clock);
        check("G_busy1", 64'(rs1_busy),  64'd1);
        check("G_grant", 64'(req_ready), 64'b010);
        next_cycle();
        req_valid = 3'b000;
        @(negedge clock);
        check("H_busy1_stage", 64'(rs1_busy),    64'd1);
        check("H_addr",        64'(rf_writeadd), 64'd3);
        check("H_en",          64'(rf_enable),   64'd1);
        next_cycle();
        @(negedge clock);
        check("I_busy1_clear", 64'(rs1_busy), 64'd0);

        // Saturate cnt[9] with three issues
        next_cycle();
        issue_valid = 1'b1;
        issue_rd = 5'd9;
        query_rs2 = 5'd9;
        @(negedge clock);
        check("J_ready", 64'(issue_ready), 64'd1);
        next_cycle();
        @(negedge clock);
        check("K_ready", 64'(issue_ready), 64'd1);
        next_cycle();
        @(negedge clock);
        check("L_ready", 64'(issue_ready), 64'd1);
        next_cycle();
        @(negedge clock);
        check("M_ready_sat", 64'(issue_ready), 64'd0);
        check("M_busy2",     64'(rs2_busy),    64'd1);

        // Issue rd 9 while requester 2 (pointer 2) writes back x9
        next_cycle();
        req_valid = 3'b100;
        set_req(2, 5'd9, 32'h99);
        @(negedge clock);
        check("N_grant",    64'(req_ready),   64'b100);
        check("N_ready_dec", 64'(issue_ready), 64'd1);
        next_cycle();
        issue_valid = 1'b0;
        req_valid = 3'b000;
        @(negedge clock);
        check("O_ready_still_sat", 64'(issue_ready),  64'd0);
        check("O_addr",            64'(rf_writeadd),  64'd9);
        check("O_data",            64'(rf_writedata), 64'h99);

        // x0 write-back (pointer 0): accepted, never enabled
        next_cycle();
        req_valid = 3'b001;
        set_req(0, 5'd0, 32'hFFFF_FFFF);
        query_rs1 = 5'd0;
        @(negedge clock);
        check("P_grant_x0", 64'(req_ready), 64'b001);
        check("P_busy_x0",  64'(rs1_busy),  64'd0);
        next_cycle();
        req_valid = 3'b000;
        @(negedge clock);
        check("Q_en_x0", 64'(rf_enable), 64'd0);

        // In-flight write, then reset pulse with requests pending
        next_cycle();
        req_valid = 3'b010;
        set_req(1, 5'd9, 32'h1234);
        @(negedge clock);
        check("R_grant", 64'(req_ready), 64'b010);
        next_cycle();
        req_valid = 3'b111;
        set_req(0, 5'd0, 32'h1);
        set_req(1, 5'd0, 32'h2);
        set_req(2, 5'd0, 32'h3);
        issue_rd = 5'd9;
        @(negedge clock);
        check("S_en",    64'(rf_enable), 64'd1);
        check("S_busy2", 64'(rs2_busy),  64'd1);
        #1 reset = 1'b1;
        #1;
        check("rstp_en",    64'(rf_enable),    64'd0);
        check("rstp_addr",  64'(rf_writeadd),  64'd0);
        check("rstp_data",  64'(rf_writedata), 64'd0);
        check("rstp_busy2", 64'(rs2_busy),     64'd0);
        check("rstp_ready", 64'(issue_ready),  64'd1);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check("T_grant_restart", 64'(req_ready), 64'b001);
        check("T_en",            64'(rf_enable), 64'd0);
        next_cycle();
        req_valid = 3'b110;
        @(negedge clock);
        check("U_grant", 64'(req_ready), 64'b010);
        next_cycle();
        req_valid = 3'b000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
